alu4_rr_sequencer: RTL



---
 rtl/alu4_pkg.sv | 36 +++
 rtl/alu4_rr_sequencer_if.sv | 48 ++++
 rtl/alu4_core.sv | 68 ++++++
 rtl/alu4_rr_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/alu4_pkg.sv
// -----------------------------------------------------------------------------
// alu4_pkg
// Shared definitions for the 4-bit ALU sequencer: opcode encodings, the
// sequencer FSM state type and a small opcode classification helper.
// -----------------------------------------------------------------------------
package alu4_pkg;

    localparam logic [3:0] OP_SHL  = 4'h0;
    localparam logic [3:0] OP_SHL2 = 4'h1;
    localparam logic [3:0] OP_SHR  = 4'h2;
    localparam logic [3:0] OP_SHRA = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_INC  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_DEC  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_EQ   = 4'hC;
    localparam logic [3:0] OP_NE   = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_LT   = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Opcodes 4..7 go through the adder and are the only ones with C/V.
    function automatic logic is_arith(input logic [3:0] op);
        return op[3:2] == 2'b01;
    endfunction

endpackage

// File: rtl/alu4_rr_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu4_rr_sequencer_if
// Bundles the two requester channels, the response channel and the status
// outputs of the sequencer.
//   master : requesters + response consumer (drives valid/op/a/b, rsp_ready)
//   slave  : the sequencer (drives readys, rsp_*, busy, op_count)
// -----------------------------------------------------------------------------
interface alu4_rr_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op;
    logic [3:0]       req0_a;
    logic [3:0]       req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op;
    logic [3:0]       req1_a;
    logic [3:0]       req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [3:0]       rsp_data;
    logic             rsp_z;
    logic             rsp_c;
    logic             rsp_v;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_z, rsp_c, rsp_v,
        input  busy, op_count
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_z, rsp_c, rsp_v,
        output busy, op_count
    );
endinterface

// File: rtl/alu4_core.sv
// -----------------------------------------------------------------------------
// alu4_core
// Purely combinational 4-bit ALU.
//   op_i[3:0], a_i[3:0], b_i[3:0] : opcode and operands
//   r_o[3:0]                       : result
//   z_o                            : result == 0
//   c_o, v_o                       : carry-out / signed overflow (opcodes 4..7)
// -----------------------------------------------------------------------------
module alu4_core
    import alu4_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] r_o,
    output logic       z_o,
    output logic       c_o,
    output logic       v_o
);
    logic [3:0] add_b;
    logic       add_cin;
    logic [4:0] sum;
    logic [3:0] shr;
    logic       carry_in3;

    // All four arithmetic opcodes share one adder: A + add_b + add_cin.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        add_b   = b_i;
        add_cin = 1'b0;
        case (op_i)
            OP_INC: add_b = 4'd1;
            OP_SUB: begin add_b = ~b_i;  add_cin = 1'b1; end
            OP_DEC: begin add_b = ~4'd1; add_cin = 1'b1; end
            default: ;
        endcase
    end

    assign sum = {1'b0, a_i} + {1'b0, add_b} + {4'b0000, add_cin};
    assign shr = b_i >> a_i[1:0];
    // Carry into bit 3 recovered from the bit-3 sum: s3 = a3 ^ b3 ^ c3.
    assign carry_in3 = a_i[3] ^ add_b[3] ^ sum[3];

    always_comb begin
        r_o = 4'd0;
        case (op_i)
            OP_SHL, OP_SHL2:               r_o = b_i << a_i[1:0];
            OP_SHR:                        r_o = shr;
            OP_SHRA:                       r_o = {b_i[3], shr[2:0]};
            OP_ADD, OP_INC, OP_SUB, OP_DEC: r_o = sum[3:0];
            OP_AND:                        r_o = a_i & b_i;
            OP_OR:                         r_o = a_i | b_i;
            OP_XOR:                        r_o = a_i ^ b_i;
            OP_NOR:                        r_o = ~(a_i | b_i);
            OP_EQ:                         r_o = {3'b000, a_i == b_i};
            OP_NE:                         r_o = {3'b000, a_i != b_i};
            OP_GT:                         r_o = {3'b000, $signed(a_i) > $signed(b_i)};
            OP_LT:                         r_o = {3'b000, $signed(a_i) < $signed(b_i)};
            default:                       r_o = 4'd0;
        endcase
    end

    assign z_o = (r_o == 4'd0);
    assign c_o = is_arith(op_i) & sum[4];
    assign v_o = is_arith(op_i) & (sum[4] ^ carry_in3);

endmodule

// File: rtl/alu4_rr_sequencer.sv
// -----------------------------------------------------------------------------
// alu4_rr_sequencer
// Shares one alu4_core between two requesters. A round-robin arbiter grants
// one request in IDLE, operands are latched, the ALU result is registered in
// EXEC and held on the response channel in RESP until rsp_ready.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : requester channels, response channel, busy and op_count
// Parameters: CNT_W (op_count width), RR_INIT (priority after reset)
// -----------------------------------------------------------------------------
module alu4_rr_sequencer
    import alu4_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter bit RR_INIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    alu4_rr_sequencer_if.slave bus
);
    state_e           state_q, state_d;
    logic             rr_ptr_q;
    logic [3:0]       op_q, a_q, b_q;
    logic             id_q;
    logic             rsp_valid_q, rsp_id_q, rsp_z_q, rsp_c_q, rsp_v_q;
    logic [3:0]       rsp_data_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_vld, grant_id, rsp_fire;
    logic [3:0]       alu_r;
    logic             alu_z, alu_c, alu_v;

    // Arbiter: a lone valid wins outright; on contention rr_ptr decides.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = rr_ptr_q;
        if (state_q == IDLE) begin
            grant_vld = bus.req0_valid | bus.req1_valid;
            if (bus.req0_valid && !bus.req1_valid) grant_id = 1'b0;
            if (bus.req1_valid && !bus.req0_valid) grant_id = 1'b1;
        end
    end

    assign bus.req0_ready = grant_vld & ~grant_id;
    assign bus.req1_ready = grant_vld &  grant_id;
    assign rsp_fire       = (state_q == RESP) & bus.rsp_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (grant_vld) state_d = EXEC;
            EXEC: state_d = RESP;
            RESP: if (bus.rsp_ready) begin
                state_d = IDLE;
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            default: state_d = IDLE;
        endcase
    end

    alu4_core u_core (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .r_o  (alu_r),
        .z_o  (alu_z),
        .c_o  (alu_c),
        .v_o  (alu_v)
    );

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: operand and response registers are reset too, so the
            // response channel reads all-zero straight out of reset.
            state_q     <= IDLE;
            rr_ptr_q    <= RR_INIT;
            op_q        <= 4'd0;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 4'd0;
            rsp_z_q     <= 1'b0;
            rsp_c_q     <= 1'b0;
            rsp_v_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant_vld) begin
                op_q     <= grant_id ? bus.req1_op : bus.req0_op;
                a_q      <= grant_id ? bus.req1_a  : bus.req0_a;
                b_q      <= grant_id ? bus.req1_b  : bus.req0_b;
                id_q     <= grant_id;
                rr_ptr_q <= ~grant_id;
            end
            if (state_q == EXEC) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_q;
                rsp_data_q  <= alu_r;
                rsp_z_q     <= alu_z;
                rsp_c_q     <= alu_c;
                rsp_v_q     <= alu_v;
            end
            if (rsp_fire) rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.rsp_c     = rsp_c_q;
    assign bus.rsp_v     = rsp_v_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.op_count  = cnt_q;

endmodule
